// File: rtl/ml_dense_core.sv
// Dense-layer engine: one time-multiplexed signed MAC walks every neuron in turn,
// then publishes the whole saturated output vector in a single cycle.
module ml_dense_core #(
    parameter int pINPUTCNT   = 4,
    parameter int pOUTPUTCNT  = 4,
    parameter int pDATA_WIDTH = 8,
    parameter int pSHIFT      = 4,
    parameter int pACC_WIDTH  = 24
) (
    input  logic                                      crypt_clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      relu_en,
    input  logic [pINPUTCNT*pDATA_WIDTH-1:0]          nn_inputs,
    input  logic [pINPUTCNT*pOUTPUTCNT*pDATA_WIDTH-1:0] nn_weights,
    input  logic [pOUTPUTCNT*pDATA_WIDTH-1:0]         nn_bias,
    output logic [pOUTPUTCNT*pDATA_WIDTH-1:0]         nn_outputs,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      trigger
);

    localparam int N  = pINPUTCNT;
    localparam int M  = pOUTPUTCNT;
    localparam int W  = pDATA_WIDTH;
    localparam int A  = pACC_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    localparam logic signed [A-1:0] MAXV = A'((1 << (W - 1)) - 1);
    localparam logic signed [A-1:0] MINV = ~MAXV;

    typedef enum logic [2:0] {IDLE, INIT, MAC, WRITE, FINISH} state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q      [N];
    logic signed [W-1:0]   w_q      [M][N];
    logic signed [W-1:0]   b_q      [M];
    logic signed [W-1:0]   result_q [M];
    logic signed [W-1:0]   out_q    [M];
    logic                  reluEn_q;
    logic signed [A-1:0]   acc_q, acc_d;
    logic [IW-1:0]         inIdx_q, inIdx_d;
    logic [JW-1:0]         neuronIdx_q, neuronIdx_d;
    logic                  done_q;
    logic                  trigger_q;

    logic                  capture;
    logic                  writeSlot;
    logic                  publish;
    logic signed [2*W-1:0] product;
    logic signed [A-1:0]   productExt;
    logic signed [A-1:0]   biasExt;
    logic signed [A-1:0]   shifted;
    logic signed [A-1:0]   clipped;
    logic signed [W-1:0]   satVal;

    // Datapath: MAC operand selection, bias alignment and the WRITE-stage rounding/clamp.
    always_comb begin
        product    = x_q[inIdx_q] * w_q[neuronIdx_q][inIdx_q];
        productExt = {{(A - 2*W){product[2*W-1]}}, product};
        biasExt    = {{(A - W){b_q[neuronIdx_q][W-1]}}, b_q[neuronIdx_q]};
        shifted    = acc_q >>> pSHIFT;
        if (reluEn_q && (shifted < 0)) begin
            clipped = '0;
        end else begin
            clipped = shifted;
        end
        if (clipped > MAXV) begin
            satVal = MAXV[W-1:0];
        end else if (clipped < MINV) begin
            satVal = MINV[W-1:0];
        end else begin
            satVal = clipped[W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        inIdx_d     = inIdx_q;
        neuronIdx_d = neuronIdx_q;
        capture     = 1'b0;
        writeSlot   = 1'b0;
        publish     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture     = 1'b1;
                    inIdx_d     = '0;
                    neuronIdx_d = '0;
                    state_d     = INIT;
                end
            end
            INIT: begin
                acc_d   = biasExt <<< pSHIFT;
                inIdx_d = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + productExt;
                if (inIdx_q == IW'(N - 1)) begin
                    state_d = WRITE;
                end else begin
                    inIdx_d = inIdx_q + IW'(1);
                end
            end
            WRITE: begin
                writeSlot = 1'b1;
                if (neuronIdx_q == JW'(M - 1)) begin
                    state_d = FINISH;
                end else begin
                    neuronIdx_d = neuronIdx_q + JW'(1);
                    state_d     = INIT;
                end
            end
            FINISH: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are shadowed on start so the buses only need to be stable for that one cycle.
    always_ff @(posedge crypt_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            inIdx_q     <= '0;
            neuronIdx_q <= '0;
            reluEn_q    <= 1'b0;
            done_q      <= 1'b0;
            trigger_q   <= 1'b0;
            for (int j = 0; j < M; j++) begin
                b_q[j]      <= '0;
                result_q[j] <= '0;
                out_q[j]    <= '0;
                for (int i = 0; i < N; i++) begin
                    w_q[j][i] <= '0;
                end
            end
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            inIdx_q     <= inIdx_d;
            neuronIdx_q <= neuronIdx_d;
            done_q      <= publish;
            trigger_q   <= (state_q != IDLE);
            if (capture) begin
                reluEn_q <= relu_en;
                for (int i = 0; i < N; i++) begin
                    x_q[i] <= nn_inputs[i*W +: W];
                end
                for (int j = 0; j < M; j++) begin
                    b_q[j] <= nn_bias[j*W +: W];
                    for (int i = 0; i < N; i++) begin
                        w_q[j][i] <= nn_weights[(j*N + i)*W +: W];
                    end
                end
            end
            if (writeSlot) begin
                result_q[neuronIdx_q] <= satVal;
            end
            // The visible vector flips all at once so a readback never sees a mix of runs.
            if (publish) begin
                for (int j = 0; j < M; j++) begin
                    out_q[j] <= result_q[j];
                end
            end
        end
    end

    always_comb begin
        nn_outputs = '0;
        for (int j = 0; j < M; j++) begin
            nn_outputs[j*W +: W] = out_q[j];
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign trigger = trigger_q;

endmodule

// File: tb/tb_ml_dense_core.sv
// Self-checking bench for ml_dense_core: directed and randomized layers compared
// against an integer reference model of the dense layer.
module tb_ml_dense_core;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = 8;
    localparam int SHIFT = 4;
    localparam int LATENCY = M * (N + 2) + 1;

    logic               crypt_clk = 1'b0;
    logic               reset;
    logic               start;
    logic               relu_en;
    logic [N*W-1:0]     nn_inputs;
    logic [N*M*W-1:0]   nn_weights;
    logic [M*W-1:0]     nn_bias;
    logic [M*W-1:0]     nn_outputs;
    logic               busy;
    logic               done;
    logic               trigger;

    int compared = 0;
    int mismatched = 0;

    int xv [N];
    int wv [M][N];
    int bv [M];
    int expY [M];
    int prevExp [M];

    int cycleCnt = 0;
    int startCycle = 0;
    int busyCnt = 0;
    int doneCnt = 0;
    int busyBase = 0;
    int doneBase = 0;

    ml_dense_core dut (
        .crypt_clk  (crypt_clk),
        .reset      (reset),
        .start      (start),
        .relu_en    (relu_en),
        .nn_inputs  (nn_inputs),
        .nn_weights (nn_weights),
        .nn_bias    (nn_bias),
        .nn_outputs (nn_outputs),
        .busy       (busy),
        .done       (done),
        .trigger    (trigger)
    );

    always #5 crypt_clk = ~crypt_clk;

    // Free-running counters used to measure latency and pulse widths.
    always @(posedge crypt_clk) cycleCnt <= cycleCnt + 1;

    always @(negedge crypt_clk) begin
        if (busy) busyCnt <= busyCnt + 1;
        if (done) doneCnt <= doneCnt + 1;
    end

    // Reference model: plain integer dot product in Q format, floor shift, ReLU, clamp.
    task automatic computeModel(input bit relu);
        int sum;
        int r;
        for (int j = 0; j < M; j++) begin
            sum = bv[j] * (1 << SHIFT);
            for (int i = 0; i < N; i++) begin
                sum += xv[i] * wv[j][i];
            end
            r = sum >>> SHIFT;
            if (relu && r < 0) r = 0;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            expY[j] = r;
        end
    endtask

    task automatic packBuses();
        for (int i = 0; i < N; i++) nn_inputs[i*W +: W] = 8'(xv[i]);
        for (int j = 0; j < M; j++) begin
            nn_bias[j*W +: W] = 8'(bv[j]);
            for (int i = 0; i < N; i++) nn_weights[(j*N + i)*W +: W] = 8'(wv[j][i]);
        end
    endtask

    task automatic scrambleBuses();
        nn_inputs  = {$urandom, $urandom};
        nn_weights = {$urandom, $urandom, $urandom, $urandom};
        nn_bias    = $urandom;
    endtask

    task automatic randomOperands();
        for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < M; j++) begin
            bv[j] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < N; i++) wv[j][i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic uniformOperands(input int x, input int w, input int b);
        for (int i = 0; i < N; i++) xv[i] = x;
        for (int j = 0; j < M; j++) begin
            bv[j] = b;
            for (int i = 0; i < N; i++) wv[j][i] = w;
        end
    endtask

    // Drives operands plus a one-cycle start; returns just after the sampling edge.
    task automatic applyStimulus(input bit relu);
        packBuses();
        relu_en = relu;
        start = 1'b1;
        @(posedge crypt_clk);
        #1;
        start = 1'b0;
        startCycle = cycleCnt;
        busyBase = busyCnt;
        doneBase = doneCnt;
    endtask

    task automatic waitDone(output bit timedOut);
        timedOut = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge crypt_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        relu_en = 1'b0;
        nn_inputs = '0;
        nn_weights = '0;
        nn_bias = '0;
        repeat (3) @(posedge crypt_clk);
        #1;
        reset = 1'b0;
        compared++;
        if (nn_outputs !== '0 || busy !== 1'b0 || done !== 1'b0 || trigger !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got out=%h busy=%b done=%b trig=%b required 0/0/0/0",
                     nn_outputs, busy, done, trigger);
        end
    endtask

    task automatic test_passthrough();
        bit to;
        uniformOperands(16, 16, 0);
        computeModel(1'b0);
        applyStimulus(1'b0);
        compared++;
        if (busy !== 1'b1 || trigger !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL start_flags: got busy=%b trig=%b required 1/0", busy, trigger);
        end
        @(posedge crypt_clk);
        #1;
        compared++;
        if (trigger !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL trigger_rise: got %b required 1", trigger);
        end
        waitDone(to);
        compared++;
        if (to || (cycleCnt - startCycle) !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL passthrough_latency: got %0d timeout=%b required %0d",
                     cycleCnt - startCycle, to, LATENCY);
        end
        compared++;
        if (busy !== 1'b0 || trigger !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL done_flags: got busy=%b trig=%b required 0/1", busy, trigger);
        end
        for (int j = 0; j < M; j++) begin
            compared++;
            if (nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL passthrough_y%0d: got %h required %h", j,
                         nn_outputs[j*W +: W], 8'(expY[j]));
            end
        end
        @(posedge crypt_clk);
        #1;
        compared++;
        if (done !== 1'b0 || trigger !== 1'b0 || (busyCnt - busyBase) !== LATENCY
            || (doneCnt - doneBase) !== 1) begin
            mismatched++;
            $display("[TB] FAIL pulse_widths: got done=%b trig=%b busyCycles=%0d doneCycles=%0d required 0/0/%0d/1",
                     done, trigger, busyCnt - busyBase, doneCnt - doneBase, LATENCY);
        end
    endtask

    task automatic test_relu();
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            uniformOperands(16, -16, 0);
            computeModel(pass[0]);
            applyStimulus(pass[0]);
            waitDone(to);
            for (int j = 0; j < M; j++) begin
                compared++;
                if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                    mismatched++;
                    $display("[TB] FAIL relu%0d_y%0d: got %h required %h timeout=%b", pass, j,
                             nn_outputs[j*W +: W], 8'(expY[j]), to);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit to;
        int wSel [2];
        wSel[0] = 127;
        wSel[1] = -128;
        for (int pass = 0; pass < 2; pass++) begin
            uniformOperands(127, wSel[pass], 0);
            computeModel(1'b0);
            applyStimulus(1'b0);
            waitDone(to);
            for (int j = 0; j < M; j++) begin
                compared++;
                if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                    mismatched++;
                    $display("[TB] FAIL saturation%0d_y%0d: got %h required %h timeout=%b", pass, j,
                             nn_outputs[j*W +: W], 8'(expY[j]), to);
                end
            end
        end
    endtask

    task automatic test_bias_index();
        bit to;
        for (int i = 0; i < N; i++) xv[i] = 16;
        for (int j = 0; j < M; j++) begin
            bv[j] = j;
            for (int i = 0; i < N; i++) wv[j][i] = 16 * (j + 1);
        end
        computeModel(1'b0);
        applyStimulus(1'b0);
        waitDone(to);
        for (int j = 0; j < M; j++) begin
            compared++;
            if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL bias_index_y%0d: got %h required %h timeout=%b", j,
                         nn_outputs[j*W +: W], 8'(expY[j]), to);
            end
        end
    endtask

    task automatic test_mid_start();
        bit to;
        randomOperands();
        computeModel(1'b1);
        applyStimulus(1'b1);
        repeat (5) @(posedge crypt_clk);
        #1;
        scrambleBuses();
        relu_en = 1'b0;
        start = 1'b1;
        @(posedge crypt_clk);
        #1;
        start = 1'b0;
        waitDone(to);
        compared++;
        if (to || (cycleCnt - startCycle) !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL mid_start_latency: got %0d required %0d timeout=%b",
                     cycleCnt - startCycle, LATENCY, to);
        end
        for (int j = 0; j < M; j++) begin
            compared++;
            if (nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL mid_start_y%0d: got %h required %h", j,
                         nn_outputs[j*W +: W], 8'(expY[j]));
            end
        end
        @(posedge crypt_clk);
        #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_start_requeued: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_operand_change();
        bit to;
        randomOperands();
        computeModel(1'b0);
        applyStimulus(1'b0);
        scrambleBuses();
        relu_en = 1'b1;
        waitDone(to);
        for (int j = 0; j < M; j++) begin
            compared++;
            if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL latched_operands_y%0d: got %h required %h timeout=%b", j,
                         nn_outputs[j*W +: W], 8'(expY[j]), to);
            end
        end
    endtask

    task automatic test_hold_until_done();
        logic [M*W-1:0] prevPacked;
        bit holdBad;
        bit sawDone;
        for (int j = 0; j < M; j++) prevPacked[j*W +: W] = 8'(expY[j]);
        randomOperands();
        computeModel(1'b0);
        applyStimulus(1'b0);
        holdBad = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            if (nn_outputs !== prevPacked) holdBad = 1'b1;
            @(posedge crypt_clk);
            #1;
        end
        compared++;
        if (holdBad || !sawDone) begin
            mismatched++;
            $display("[TB] FAIL hold_until_done: early_change=%b done_seen=%b required 0/1",
                     holdBad, sawDone);
        end
        for (int j = 0; j < M; j++) begin
            compared++;
            if (nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL hold_new_y%0d: got %h required %h", j,
                         nn_outputs[j*W +: W], 8'(expY[j]));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        randomOperands();
        applyStimulus(1'b0);
        repeat (9) @(posedge crypt_clk);
        #1;
        reset = 1'b1;
        @(posedge crypt_clk);
        #1;
        reset = 1'b0;
        compared++;
        if (nn_outputs !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_run: got out=%h busy=%b done=%b required 0/0/0",
                     nn_outputs, busy, done);
        end
        doneBase = doneCnt;
        repeat (30) @(posedge crypt_clk);
        #1;
        compared++;
        if ((doneCnt - doneBase) !== 0) begin
            mismatched++;
            $display("[TB] FAIL aborted_done: got %0d pulses required 0", doneCnt - doneBase);
        end
        randomOperands();
        computeModel(1'b1);
        applyStimulus(1'b1);
        waitDone(to);
        compared++;
        if (to || (cycleCnt - startCycle) !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL post_reset_latency: got %0d required %0d timeout=%b",
                     cycleCnt - startCycle, LATENCY, to);
        end
        for (int j = 0; j < M; j++) begin
            compared++;
            if (nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL post_reset_y%0d: got %h required %h", j,
                         nn_outputs[j*W +: W], 8'(expY[j]));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        randomOperands();
        computeModel(1'b0);
        applyStimulus(1'b0);
        waitDone(to);
        for (int j = 0; j < M; j++) begin
            compared++;
            if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL b2b_first_y%0d: got %h required %h timeout=%b", j,
                         nn_outputs[j*W +: W], 8'(expY[j]), to);
            end
        end
        randomOperands();
        computeModel(1'b1);
        applyStimulus(1'b1);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_accept: got busy=%b required 1", busy);
        end
        waitDone(to);
        compared++;
        if (to || (cycleCnt - startCycle) !== LATENCY) begin
            mismatched++;
            $display("[TB] FAIL b2b_latency: got %0d required %0d timeout=%b",
                     cycleCnt - startCycle, LATENCY, to);
        end
        for (int j = 0; j < M; j++) begin
            compared++;
            if (nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                mismatched++;
                $display("[TB] FAIL b2b_second_y%0d: got %h required %h", j,
                         nn_outputs[j*W +: W], 8'(expY[j]));
            end
        end
    endtask

    task automatic test_random();
        bit to;
        bit relu;
        for (int iter = 0; iter < 10; iter++) begin
            randomOperands();
            relu = 1'($urandom_range(0, 1));
            computeModel(relu);
            applyStimulus(relu);
            waitDone(to);
            for (int j = 0; j < M; j++) begin
                compared++;
                if (to || nn_outputs[j*W +: W] !== 8'(expY[j])) begin
                    mismatched++;
                    $display("[TB] FAIL random%0d_y%0d: got %h required %h relu=%b timeout=%b",
                             iter, j, nn_outputs[j*W +: W], 8'(expY[j]), relu, to);
                end
            end
            @(posedge crypt_clk);
            #1;
        end
    endtask

    // Scenario sequence; each task leaves the bench just after a rising edge.
    initial begin
        test_reset();
        test_passthrough();
        test_relu();
        test_saturation();
        test_bias_index();
        test_mid_start();
        test_operand_change();
        test_hold_until_done();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
